// File: rtl/tiny_riscv_mmio_pkg.sv
// Shared definitions for the tiny_riscv_mmio block: I/O register indices,
// byte-mask expansion and the hex-to-seven-segment decoder.
package tiny_riscv_mmio_pkg;

    localparam logic [2:0] REG_LED     = 3'd0;
    localparam logic [2:0] REG_SW      = 3'd1;
    localparam logic [2:0] REG_SW_EDGE = 3'd2;
    localparam logic [2:0] REG_SEG     = 3'd3;
    localparam logic [2:0] REG_TIMER   = 3'd4;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    function automatic logic [31:0] expand_mask(input logic [3:0] wmask);
        return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    endfunction

    // Active-low segments, bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tiny_riscv_mmio_debounce.sv
// One switch channel: two-flop synchroniser, stability counter and the
// accepted level, plus a pulse on the cycle a 0->1 change is accepted.
module tiny_riscv_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_N,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    assign accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
    assign o_rise   = accept_s & sync2_r;
    assign o_stable = stable_r;

    // Synchronise the raw input and accept it only after it has held for the full window.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            sync1_r <= i_raw;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (accept_s) begin
                stable_r <= sync2_r;
                cnt_r    <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/tiny_riscv_mmio.sv
// Splits processor accesses into RAM or peripheral register accesses and
// owns the LEDs, debounced switches, seven-segment display and cycle timer.
module tiny_riscv_mmio
    import tiny_riscv_mmio_pkg::*;
#(
    parameter int N_LED           = 4,
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int IO_SEL_BIT      = 22
) (
    input  logic              i_Clk,
    input  logic              i_Rst_N,
    input  logic [31:0]       i_mem_addr,
    input  logic              i_read_strobe,
    input  logic              i_write_strobe,
    input  logic [31:0]       i_mem_wdata,
    input  logic [3:0]        i_mem_wmask,
    output logic [31:0]       o_mem_rdata,
    output logic [31:0]       o_ram_addr,
    output logic              o_ram_read_strobe,
    output logic              o_ram_write_strobe,
    output logic [31:0]       o_ram_wdata,
    output logic [3:0]        o_ram_wmask,
    input  logic [31:0]       i_ram_rdata,
    input  logic [N_SW-1:0]   i_Switch,
    output logic [N_LED-1:0]  o_LED,
    output logic [6:0]        o_Segment1,
    output logic [6:0]        o_Segment2
);

    logic              io_sel_s;
    logic [2:0]        reg_idx_s;
    logic              io_wr_s;
    logic [31:0]       wm_s;
    logic [31:0]       rd_mux_s;
    logic [N_SW-1:0]   edge_clr_s;
    logic [N_SW-1:0]   stable_s;
    logic [N_SW-1:0]   rise_s;
    logic              unused_wmask_s;

    logic [N_LED-1:0]  led_r;
    logic [7:0]        seg_r;
    logic [N_SW-1:0]   sw_edge_r;
    logic [31:0]       timer_r;
    logic [31:0]       io_rdata_r;
    logic              io_flag_r;
    logic [6:0]        seg1_r;
    logic [6:0]        seg2_r;

    assign io_sel_s  = i_mem_addr[IO_SEL_BIT];
    assign reg_idx_s = i_mem_addr[4:2];
    assign io_wr_s   = i_write_strobe & io_sel_s;
    assign wm_s      = expand_mask(i_mem_wmask);
    assign unused_wmask_s = ^wm_s;

    assign o_ram_addr         = i_mem_addr;
    assign o_ram_read_strobe  = i_read_strobe & ~io_sel_s;
    assign o_ram_write_strobe = i_write_strobe & ~io_sel_s;
    assign o_ram_wdata        = i_mem_wdata;
    assign o_ram_wmask        = i_mem_wmask;

    assign o_mem_rdata = io_flag_r ? io_rdata_r : i_ram_rdata;
    assign o_LED       = led_r;
    assign o_Segment1  = seg1_r;
    assign o_Segment2  = seg2_r;

    genvar g;
    generate
        for (g = 0; g < N_SW; g++) begin : g_sw
            tiny_riscv_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_Clk   (i_Clk),
                .i_Rst_N (i_Rst_N),
                .i_raw   (i_Switch[g]),
                .o_stable(stable_s[g]),
                .o_rise  (rise_s[g])
            );
        end
    endgenerate

    // I/O read data mux; narrow registers are zero-extended.
    always_comb begin
        rd_mux_s = 32'd0;
        case (reg_idx_s)
            REG_LED:     rd_mux_s = 32'(led_r);
            REG_SW:      rd_mux_s = 32'(stable_s);
            REG_SW_EDGE: rd_mux_s = 32'(sw_edge_r);
            REG_SEG:     rd_mux_s = {24'd0, seg_r};
            REG_TIMER:   rd_mux_s = timer_r;
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Write-1-to-clear bits for the sticky edge flags, honouring byte enables.
    always_comb begin
        edge_clr_s = {N_SW{1'b0}};
        if (io_wr_s && (reg_idx_s == REG_SW_EDGE)) begin
            edge_clr_s = i_mem_wdata[N_SW-1:0] & wm_s[N_SW-1:0];
        end else begin
            edge_clr_s = {N_SW{1'b0}};
        end
    end

    // Peripheral state; reads sample pre-write values, and a new edge beats a clear.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            led_r      <= {N_LED{1'b0}};
            seg_r      <= 8'd0;
            sw_edge_r  <= {N_SW{1'b0}};
            timer_r    <= 32'd0;
            io_rdata_r <= 32'd0;
            io_flag_r  <= 1'b0;
            seg1_r     <= SEG_ZERO;
            seg2_r     <= SEG_ZERO;
        end else begin
            timer_r <= timer_r + 32'd1;
            if (i_read_strobe) begin
                io_flag_r <= io_sel_s;
                if (io_sel_s) begin
                    io_rdata_r <= rd_mux_s;
                end
            end
            if (io_wr_s && (reg_idx_s == REG_LED)) begin
                led_r <= (led_r & ~wm_s[N_LED-1:0]) | (i_mem_wdata[N_LED-1:0] & wm_s[N_LED-1:0]);
            end
            if (io_wr_s && (reg_idx_s == REG_SEG)) begin
                seg_r <= (seg_r & ~wm_s[7:0]) | (i_mem_wdata[7:0] & wm_s[7:0]);
            end
            sw_edge_r <= (sw_edge_r & ~edge_clr_s) | rise_s;
            seg1_r    <= hex_to_seg(seg_r[7:4]);
            seg2_r    <= hex_to_seg(seg_r[3:0]);
        end
    end

endmodule

// File: tb/tb_tiny_riscv_mmio.sv
// Scoreboard bench for tiny_riscv_mmio: reads push expected data, a monitor
// compares o_mem_rdata one cycle later; side outputs are checked inline.
module tb_tiny_riscv_mmio;

    localparam int N_LED = 4;
    localparam int N_SW  = 4;
    localparam int DEB   = 8;
    localparam logic [31:0] IO_BASE = 32'h0040_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       mem_addr = 32'd0;
    logic              read_strobe = 1'b0;
    logic              write_strobe = 1'b0;
    logic [31:0]       mem_wdata = 32'd0;
    logic [3:0]        mem_wmask = 4'd0;
    logic [31:0]       mem_rdata;
    logic [31:0]       ram_addr;
    logic              ram_read_strobe;
    logic              ram_write_strobe;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wmask;
    logic [31:0]       ram_rdata = 32'd0;
    logic [N_SW-1:0]   sw = '0;
    logic [N_LED-1:0]  led;
    logic [6:0]        seg1;
    logic [6:0]        seg2;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic rd_seen = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    tiny_riscv_mmio #(
        .N_LED(N_LED), .N_SW(N_SW), .DEBOUNCE_CYCLES(DEB), .IO_SEL_BIT(22)
    ) dut (
        .i_Clk(clk), .i_Rst_N(rst_n),
        .i_mem_addr(mem_addr), .i_read_strobe(read_strobe), .i_write_strobe(write_strobe),
        .i_mem_wdata(mem_wdata), .i_mem_wmask(mem_wmask), .o_mem_rdata(mem_rdata),
        .o_ram_addr(ram_addr), .o_ram_read_strobe(ram_read_strobe),
        .o_ram_write_strobe(ram_write_strobe), .o_ram_wdata(ram_wdata), .o_ram_wmask(ram_wmask),
        .i_ram_rdata(ram_rdata), .i_Switch(sw), .o_LED(led),
        .o_Segment1(seg1), .o_Segment2(seg2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_seen <= read_strobe;

    // Read-data monitor: one cycle after each read strobe, pop and compare.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rdata_unexpected: got %h, expected no read", mem_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, mem_rdata, e.data);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] ramd);
        @(negedge clk);
        #1;
        read_strobe  = rd;
        write_strobe = wr;
        mem_addr     = addr;
        mem_wdata    = wdata;
        mem_wmask    = mask;
        ram_rdata    = ramd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'hFFFF_FFFF);
    endtask

    function automatic logic [31:0] io_addr(input logic [2:0] idx);
        return IO_BASE | {27'd0, idx, 2'b00};
    endfunction

    task automatic io_rd(input string name, input logic [2:0] idx, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.data = exp;
        exp_q.push_back(e);
        drive(1'b1, 1'b0, io_addr(idx), 32'd0, 4'd0, 32'hFFFF_FFFF);
    endtask

    task automatic io_wr(input logic [2:0] idx, input logic [31:0] wdata, input logic [3:0] mask);
        drive(1'b0, 1'b1, io_addr(idx), wdata, mask, 32'hFFFF_FFFF);
    endtask

    initial begin
        exp_t e;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("rst_led", {28'd0, led}, 32'd0);
        check("rst_seg1", {25'd0, seg1}, {25'd0, 7'b1000000});
        check("rst_seg2", {25'd0, seg2}, {25'd0, 7'b1000000});
        io_rd("rst_rd_led", 3'd0, 32'd0);
        io_rd("rst_rd_sw", 3'd1, 32'd0);
        io_rd("rst_rd_edge", 3'd2, 32'd0);
        io_rd("rst_rd_seg", 3'd3, 32'd0);
        idle(1);

        io_wr(3'd0, 32'h0000_000A, 4'b0001);
        idle(1);
        check("led_write", {28'd0, led}, 32'h0000_000A);
        io_wr(3'd0, 32'h0000_0005, 4'b0000);
        idle(1);
        check("led_masked_off", {28'd0, led}, 32'h0000_000A);
        e.name = "rd_led_lowbits";
        e.data = 32'h0000_000A;
        exp_q.push_back(e);
        drive(1'b1, 1'b0, io_addr(3'd0) | 32'd3, 32'd0, 4'd0, 32'hFFFF_FFFF);

        sw[0] = 1'b1;
        idle(5);
        sw[0] = 1'b0;
        idle(15);
        io_rd("sw_glitch", 3'd1, 32'd0);
        io_rd("edge_glitch", 3'd2, 32'd0);
        sw[0] = 1'b1;
        idle(20);
        io_rd("sw_level", 3'd1, 32'h0000_0001);
        io_rd("sw_edge_set", 3'd2, 32'h0000_0001);
        io_wr(3'd2, 32'h0000_0001, 4'b0001);
        io_rd("sw_edge_w1c", 3'd2, 32'd0);
        io_rd("sw_level_kept", 3'd1, 32'h0000_0001);

        io_wr(3'd3, 32'h0000_003F, 4'b0001);
        idle(2);
        check("seg1_3", {25'd0, seg1}, {25'd0, 7'b0110000});
        check("seg2_F", {25'd0, seg2}, {25'd0, 7'b0001110});
        io_rd("rd_seg", 3'd3, 32'h0000_003F);

        e.name = "mem_rdata";
        e.data = 32'hDEAD_BEEF;
        exp_q.push_back(e);
        drive(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'd0, 32'hDEAD_BEEF);
        check("ram_rd_strobe_n", {31'd0, ram_read_strobe}, 32'd1);
        check("ram_addr", ram_addr, 32'h0000_0100);
        io_rd("io_after_mem", 3'd0, 32'h0000_000A);
        check("ram_rd_strobe_io", {31'd0, ram_read_strobe}, 32'd0);
        idle(1);
        check("ram_rd_strobe_n1", {31'd0, ram_read_strobe}, 32'd0);

        drive(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b1010, 32'hFFFF_FFFF);
        check("ram_wr_strobe", {31'd0, ram_write_strobe}, 32'd1);
        check("ram_wdata", ram_wdata, 32'h1234_5678);
        check("ram_wmask", {28'd0, ram_wmask}, 32'h0000_000A);
        io_wr(3'd5, 32'hFFFF_FFFF, 4'b1111);
        check("ram_wr_strobe_io", {31'd0, ram_write_strobe}, 32'd0);
        io_rd("unmapped5", 3'd5, 32'd0);
        io_rd("unmapped6", 3'd6, 32'd0);

        e.name = "rw_same_cycle";
        e.data = 32'h0000_000A;
        exp_q.push_back(e);
        drive(1'b1, 1'b1, io_addr(3'd0), 32'h0000_0003, 4'b0001, 32'hFFFF_FFFF);
        idle(1);
        check("led_after_rw", {28'd0, led}, 32'h0000_0003);

        @(negedge clk);
        force dut.timer_r = 32'hFFFF_FFFE;
        @(negedge clk);
        force dut.timer_r = 32'hFFFF_FFFF;
        release dut.timer_r;
        io_rd("timer_wrap0", 3'd4, 32'h0000_0000);
        io_rd("timer_wrap1", 3'd4, 32'h0000_0001);
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
